orv64_pmp_checker_pipe: RTL and testbench
=========================================

ORV64_PMP_CHECKER_PIPE -- requirements
Module: orv64_pmp_checker_pipe

Interface
REQ-001 SHALL: parameter N_ENTRIES, default 16, number of PMP entries (1..64).
REQ-002 SHALL: parameter PADDR_W, default 56, physical address width.
REQ-003 SHALL: parameter VALID_PA_W, default 32, implemented PA width; higher bits must be zero.
REQ-004 SHALL: parameter ID_W, default 4, request tag width.
REQ-005 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL: rst  in  1  synchronous, active-high reset.
REQ-007 SHALL: cfg_update  in  1  one-cycle pulse, pmpcfg/pmpaddr CSR was written.
REQ-008 SHALL: pmpcfg  in  8*N_ENTRIES  live cfg bytes {L,2'b0,A[1:0],X,W,R}.
REQ-009 SHALL: pmpaddr  in  (PADDR_W-2)*N_ENTRIES  live pmpaddr values.
REQ-010 SHALL: prv  in  2  current privilege (0 U, 1 S, 3 M).
REQ-011 SHALL: mprv / mpp  in  1 / 2  mstatus.MPRV and mstatus.MPP.
REQ-012 SHALL: req_valid / req_ready  in / out  1  request handshake.
REQ-013 SHALL: req_paddr  in  PADDR_W; req_type  in  2 (0 fetch, 1 load, 2 store/AMO); req_bytes  in  4 (1..8); req_id  in  ID_W.
REQ-014 SHALL: resp_valid / resp_ready  out / in  1  response handshake.
REQ-015 SHALL: resp_fault  out  1; resp_cause  out  4; resp_id  out  ID_W.
REQ-016 SHALL: fault_cnt  out  16  saturating count of faulting responses.

Function
REQ-017 SHALL: config snapshot registers hold pmpcfg/pmpaddr; all checks use snapshot, never live inputs.
REQ-018 SHALL: cfg_update sets cfg_pending; while cfg_pending, req_ready=0.
REQ-019 SHALL: when cfg_pending and both pipeline stages empty, snapshot loads live inputs and cfg_pending clears same edge; req_ready may rise next cycle.
REQ-020 SHALL: cfg_update arriving while cfg_pending already set is absorbed (single reload, using values live at reload edge).
REQ-021 SHALL: stage S1 captures request on req_valid&&req_ready and registers per-entry full-match and overlap vectors computed from snapshot.
REQ-022 SHALL: stage S2 performs lowest-index priority select, permission check, registers response; resp_valid asserted 2 cycles after acceptance with no backpressure.
REQ-023 SHALL: S2 holds when resp_valid&&!resp_ready; S1 advances only if S2 empty or draining; req_ready=!cfg_pending && (!S1 full || S1 advancing); full throughput 1/cycle.
REQ-024 SHALL: access range base=req_paddr, bound=req_paddr+req_bytes-1 at PADDR_W; carry out of PADDR_W is a fault.
REQ-025 SHALL: A=OFF never matches; TOR i: lo=(i==0?0:pmpaddr[i-1]<<2), hi=pmpaddr[i]<<2, range [lo,hi), empty if lo>=hi; NA4: [pmpaddr<<2, +4); NAPOT: k trailing ones, size 2^(k+3), base pmpaddr with low k+1 bits cleared, <<2.
REQ-026 SHALL: winning entry = lowest index with any overlap; if that entry does not fully contain range, fault regardless of privilege.
REQ-027 SHALL: effective prv = prv for fetch, else (mprv ? mpp : prv).
REQ-028 SHALL: full-match entry enforced when effective prv!=M or L=1; fetch needs X, load R, store W.
REQ-029 SHALL: no overlap: fault if effective prv!=M and any snapshot entry A!=OFF; else pass.
REQ-030 SHALL: any req_paddr bit at or above VALID_PA_W set -> fault.
REQ-031 SHALL: resp_cause = 1 fetch, 5 load, 7 store when resp_fault=1; 0 otherwise; resp_id echoes req_id.
REQ-032 SHALL: fault_cnt increments once per resp_valid&&resp_ready&&resp_fault, saturating at 16'hFFFF.

Reset
REQ-033 SHALL: rst clears S1/S2 valid, resp_valid, resp_fault, resp_cause, resp_id, fault_cnt to 0, snapshot to all A=OFF, and sets cfg_pending=1 (first reload after reset).
REQ-034 SHALL: rst mid-transaction discards in-flight requests without producing responses.

Verification
REQ-035 SHALL: NAPOT entry0 pmpaddr=0x2000_01FF (4 KiB @0x8000_0000), R only, prv=U, load 8B @0x8000_0FF8 -> pass; store same -> fault cause 7, 2-cycle latency.
REQ-036 SHALL: entry0 TOR hi 0x1000 RWX, prv=U, load 8B @0x0FFC -> partial match fault cause 5; @0x0FF8 -> pass.
REQ-037 SHALL: prv=M, mprv=1, mpp=U, no matching entry but entry3 configured -> load fault; fetch same address -> pass.
REQ-038 SHALL: back-to-back 4 requests with resp_ready low 3 cycles -> req_ready drops after S1/S2 fill, responses in order, ids preserved, none lost.
REQ-039 SHALL: cfg_update with 2 requests in flight -> both checked against old snapshot, req_ready low until drain, next request uses new config.
REQ-040 SHALL: paddr=0x1_0000_0000, VALID_PA_W=32 -> fault; fault_cnt at 0xFFFF stays 0xFFFF after further faults.

Source files
------------

// File: rtl/orv64_pmp_checker_pipe.sv
// Two-stage PMP checker: S1 registers per-entry match/overlap vectors against a
// config snapshot, S2 does priority select and permission check.
module orv64_pmp_checker_pipe #(
  parameter int unsigned N_ENTRIES  = 16,
  parameter int unsigned PADDR_W    = 56,
  parameter int unsigned VALID_PA_W = 32,
  parameter int unsigned ID_W       = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_update,
  input  logic [8*N_ENTRIES-1:0]            pmpcfg,
  input  logic [(PADDR_W-2)*N_ENTRIES-1:0]  pmpaddr,
  input  logic [1:0]                        prv,
  input  logic                              mprv,
  input  logic [1:0]                        mpp,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [PADDR_W-1:0]                req_paddr,
  input  logic [1:0]                        req_type,
  input  logic [3:0]                        req_bytes,
  input  logic [ID_W-1:0]                   req_id,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic                              resp_fault,
  output logic [3:0]                        resp_cause,
  output logic [ID_W-1:0]                   resp_id,
  output logic [15:0]                       fault_cnt
);

  localparam int unsigned AW = PADDR_W - 2;
  localparam int unsigned EW = PADDR_W + 1;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam logic [1:0] T_FETCH = 2'd0;
  localparam logic [1:0] T_LOAD  = 2'd1;
  localparam logic [1:0] PRV_M   = 2'd3;

  typedef enum logic [0:0] {
    CFG_READY   = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_t;

  cfg_state_t state_q, state_nxt;
  logic       reload_c;

  logic [7:0]    snap_cfg  [N_ENTRIES];
  logic [AW-1:0] snap_addr [N_ENTRIES];

  logic                 s1_valid;
  logic [1:0]           s1_type;
  logic [ID_W-1:0]      s1_id;
  logic                 s1_eff_m;
  logic                 s1_range_fault;
  logic [N_ENTRIES-1:0] s1_full;
  logic [N_ENTRIES-1:0] s1_overlap;

  logic                 s2_free;
  logic                 s1_adv;
  logic                 accept;
  logic [N_ENTRIES-1:0] active;
  logic [N_ENTRIES-1:0] full_c;
  logic [N_ENTRIES-1:0] overlap_c;

  // Handshake: the snapshot may only change while nothing is in flight.
  assign s2_free   = !resp_valid || resp_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign req_ready = (state_q == CFG_READY) && (!s1_valid || s2_free);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= CFG_PENDING;
    else     state_q <= state_nxt;
  end

  // Later cfg_update pulses while pending fold into the single reload.
  always_comb begin
    state_nxt = state_q;
    reload_c  = 1'b0;
    case (state_q)
      CFG_READY: begin
        if (cfg_update) state_nxt = CFG_PENDING;
      end
      CFG_PENDING: begin
        if (!s1_valid && !resp_valid) begin
          reload_c  = 1'b1;
          state_nxt = CFG_READY;
        end
      end
      default: state_nxt = CFG_PENDING;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        snap_cfg[i]  <= '0;
        snap_addr[i] <= '0;
      end
    end else if (reload_c) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        snap_cfg[i]  <= pmpcfg[8*i +: 8];
        snap_addr[i] <= pmpaddr[AW*i +: AW];
      end
    end
  end

  // Access range [acc_lo, acc_hi], one bit wider to expose the carry.
  logic [EW-1:0] acc_lo;
  logic [EW-1:0] acc_hi;
  logic          pa_hi_c;
  logic [1:0]    eff_prv_c;

  assign acc_lo = {1'b0, req_paddr};
  assign acc_hi = acc_lo + EW'(req_bytes) - EW'(1);

  if (VALID_PA_W < PADDR_W) begin : g_pa_chk
    assign pa_hi_c = |req_paddr[PADDR_W-1:VALID_PA_W];
  end else begin : g_pa_none
    assign pa_hi_c = 1'b0;
  end

  assign eff_prv_c = (req_type == T_FETCH) ? prv : (mprv ? mpp : prv);

  // Per-entry region decode, [reg_lo, reg_hi) in bytes.
  for (genvar g = 0; g < int'(N_ENTRIES); g++) begin : g_region
    logic [AW-1:0] tor_lo_w;
    logic [AW-1:0] nmask;
    logic [EW-1:0] reg_lo;
    logic [EW-1:0] reg_hi;
    logic          nonempty;
    logic          unused_rsvd;

    if (g == 0) begin : g_first
      assign tor_lo_w = '0;
    end else begin : g_rest
      assign tor_lo_w = snap_addr[g-1];
    end

    // Trailing ones plus the first zero give the NAPOT word mask.
    assign nmask = snap_addr[g] ^ (snap_addr[g] + AW'(1));

    always_comb begin
      reg_lo = '0;
      reg_hi = '0;
      case (snap_cfg[g][4:3])
        A_TOR: begin
          reg_lo = {1'b0, tor_lo_w, 2'b00};
          reg_hi = {1'b0, snap_addr[g], 2'b00};
        end
        A_NA4: begin
          reg_lo = {1'b0, snap_addr[g], 2'b00};
          reg_hi = {1'b0, snap_addr[g], 2'b00} + EW'(4);
        end
        A_NAPOT: begin
          reg_lo = {1'b0, snap_addr[g] & ~nmask, 2'b00};
          reg_hi = {1'b0, snap_addr[g] & ~nmask, 2'b00} + {1'b0, nmask, 2'b00} + EW'(4);
        end
        default: begin
          reg_lo = '0;
          reg_hi = '0;
        end
      endcase
    end

    assign active[g]    = (snap_cfg[g][4:3] != A_OFF);
    assign nonempty     = active[g] && (reg_lo < reg_hi);
    assign overlap_c[g] = nonempty && (acc_lo < reg_hi) && (acc_hi >= reg_lo);
    assign full_c[g]    = nonempty && (acc_lo >= reg_lo) && (acc_hi < reg_hi);
    assign unused_rsvd  = ^snap_cfg[g][6:5];
  end

  // Stage 1: capture request with its match vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid       <= 1'b0;
      s1_type        <= '0;
      s1_id          <= '0;
      s1_eff_m       <= 1'b0;
      s1_range_fault <= 1'b0;
      s1_full        <= '0;
      s1_overlap     <= '0;
    end else if (accept) begin
      s1_valid       <= 1'b1;
      s1_type        <= req_type;
      s1_id          <= req_id;
      s1_eff_m       <= (eff_prv_c == PRV_M);
      s1_range_fault <= acc_hi[PADDR_W] | pa_hi_c;
      s1_full        <= full_c;
      s1_overlap     <= overlap_c;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: lowest-index overlapping entry decides.
  logic       win_found;
  logic       win_full;
  logic [7:0] win_cfg;
  logic       perm_ok;
  logic       fault_c;
  logic [3:0] cause_c;

  always_comb begin
    win_found = 1'b0;
    win_full  = 1'b0;
    win_cfg   = '0;
    for (int i = int'(N_ENTRIES) - 1; i >= 0; i--) begin
      if (s1_overlap[i]) begin
        win_found = 1'b1;
        win_full  = s1_full[i];
        win_cfg   = snap_cfg[i];
      end
    end
  end

  always_comb begin
    perm_ok = 1'b0;
    cause_c = 4'd7;
    case (s1_type)
      T_FETCH: begin perm_ok = win_cfg[2]; cause_c = 4'd1; end
      T_LOAD:  begin perm_ok = win_cfg[0]; cause_c = 4'd5; end
      default: begin perm_ok = win_cfg[1]; cause_c = 4'd7; end
    endcase
  end

  always_comb begin
    fault_c = s1_range_fault;
    if (win_found) begin
      if (!win_full)                                  fault_c = 1'b1;
      else if ((!s1_eff_m || win_cfg[7]) && !perm_ok) fault_c = 1'b1;
    end else if (!s1_eff_m && (|active)) begin
      fault_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_cause <= '0;
      resp_id    <= '0;
    end else if (s2_free) begin
      resp_valid <= s1_valid;
      resp_fault <= s1_valid && fault_c;
      resp_cause <= (s1_valid && fault_c) ? cause_c : 4'd0;
      resp_id    <= s1_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_cnt <= '0;
    end else if (resp_valid && resp_ready && resp_fault && (fault_cnt != 16'hFFFF)) begin
      fault_cnt <= fault_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_orv64_pmp_checker_pipe.sv
// Scoreboard bench for orv64_pmp_checker_pipe: expected responses are queued at
// acceptance and checked in order as the DUT hands them out.
module tb_orv64_pmp_checker_pipe;

  localparam int unsigned N  = 16;
  localparam int unsigned PW = 56;
  localparam int unsigned AW = PW - 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_update;
  logic [8*N-1:0]    pmpcfg;
  logic [AW*N-1:0]   pmpaddr;
  logic [1:0]        prv;
  logic              mprv;
  logic [1:0]        mpp;
  logic              req_valid;
  logic              req_ready;
  logic [PW-1:0]     req_paddr;
  logic [1:0]        req_type;
  logic [3:0]        req_bytes;
  logic [3:0]        req_id;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_fault;
  logic [3:0]        resp_cause;
  logic [3:0]        resp_id;
  logic [15:0]       fault_cnt;

  orv64_pmp_checker_pipe #(
    .N_ENTRIES(N), .PADDR_W(PW), .VALID_PA_W(32), .ID_W(4)
  ) dut (
    .clk(clk), .rst(rst), .cfg_update(cfg_update), .pmpcfg(pmpcfg), .pmpaddr(pmpaddr),
    .prv(prv), .mprv(mprv), .mpp(mpp), .req_valid(req_valid), .req_ready(req_ready),
    .req_paddr(req_paddr), .req_type(req_type), .req_bytes(req_bytes), .req_id(req_id),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_fault(resp_fault),
    .resp_cause(resp_cause), .resp_id(resp_id), .fault_cnt(fault_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fault;
    logic [3:0] cause;
    logic [3:0] id;
    int         acc_cyc;
    bit         chk_lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_faults = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] cause_of(input logic [1:0] ty);
    if (ty == 2'd0)      return 4'd1;
    else if (ty == 2'd1) return 4'd5;
    else                 return 4'd7;
  endfunction

  // Response side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && resp_valid && resp_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_resp: got id=%0d fault=%0b with nothing outstanding", resp_id, resp_fault);
      end else begin
        e = sb.pop_front();
        if ({resp_fault, resp_cause, resp_id} !== {e.fault, e.cause, e.id}) begin
          n_err++;
          $display("FAIL resp: got fault=%0b cause=%0d id=%0d, want fault=%0b cause=%0d id=%0d",
                   resp_fault, resp_cause, resp_id, e.fault, e.cause, e.id);
        end
        if (e.chk_lat) begin
          n_cmp++;
          if ((cyc - e.acc_cyc) != 2) begin
            n_err++;
            $display("FAIL latency id=%0d: got %0d cycles, want 2", e.id, cyc - e.acc_cyc);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [PW-1:0] pa, input logic [1:0] ty, input logic [3:0] nb,
                      input logic [3:0] id, input logic flt, input bit chk_lat);
    exp_t e;
    req_valid = 1'b1;
    req_paddr = pa;
    req_type  = ty;
    req_bytes = nb;
    req_id    = id;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready) begin
        e.fault = flt;
        e.cause = flt ? cause_of(ty) : 4'd0;
        e.id = id;
        e.acc_cyc = cyc;
        e.chk_lat = chk_lat;
        sb.push_back(e);
        if (flt) exp_faults++;
        @(posedge clk);
        #1;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL accept_timeout: id=%0d never accepted, req_ready=%0b", id, req_ready);
    req_valid = 1'b0;
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      if (sb.size() == 0 && !resp_valid) done = 1'b1;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL drain_%s: %0d responses still outstanding, want 0", tag, sb.size());
    end
  endtask

  task automatic check_cnt(input string tag);
    logic [15:0] want;
    want = (exp_faults > 65535) ? 16'hFFFF : 16'(exp_faults);
    n_cmp++;
    if (fault_cnt !== want) begin
      n_err++;
      $display("FAIL fault_cnt_%s: got %0h, want %0h", tag, fault_cnt, want);
    end
  endtask

  task automatic clear_cfg();
    pmpcfg  = '0;
    pmpaddr = '0;
  endtask

  task automatic set_entry(input int i, input logic [7:0] c, input logic [AW-1:0] a);
    pmpcfg[8*i +: 8]   = c;
    pmpaddr[AW*i +: AW] = a;
  endtask

  // Pulse cfg_update and wait until the reload has opened the request port.
  task automatic apply_cfg();
    bit up = 1'b0;
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
    for (int t = 0; t < 50 && !up; t++) begin
      @(negedge clk);
      if (req_ready) up = 1'b1;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (!up) begin
      n_err++;
      $display("FAIL cfg_reload: req_ready stuck at %0b, want 1", req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({resp_valid, req_ready, fault_cnt} !== {1'b0, 1'b0, 16'h0}) begin
      n_err++;
      $display("FAIL reset_state: got resp_valid=%0b req_ready=%0b fault_cnt=%0h, want 0 0 0",
               resp_valid, req_ready, fault_cnt);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pending: got req_ready=%0b, want 0 before first reload", req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_reload: got req_ready=%0b, want 1 after first reload", req_ready);
    end
    @(posedge clk);
    #1;
    send(56'h1000, 2'd1, 4'd8, 4'd1, 1'b0, 1'b1);
    idle();
    wait_drain("reset");
    check_cnt("reset");
  endtask

  task automatic test_napot();
    clear_cfg();
    set_entry(0, 8'h19, 54'h2000_01FF);
    prv = 2'd0; mprv = 1'b0; mpp = 2'd0;
    apply_cfg();
    send(56'h8000_0FF8, 2'd1, 4'd8, 4'd2, 1'b0, 1'b1);
    send(56'h8000_0FF8, 2'd2, 4'd8, 4'd3, 1'b1, 1'b1);
    send(56'h8000_0000, 2'd0, 4'd4, 4'd4, 1'b1, 1'b1);
    send(56'h8000_1000, 2'd1, 4'd4, 4'd5, 1'b1, 1'b1);
    send(56'h7FFF_FFFC, 2'd1, 4'd8, 4'd6, 1'b1, 1'b1);
    send(56'h8000_0000, 2'd1, 4'd1, 4'd7, 1'b0, 1'b1);
    idle();
    wait_drain("napot");
    check_cnt("napot");
  endtask

  task automatic test_tor();
    clear_cfg();
    set_entry(0, 8'h0F, 54'h400);
    set_entry(1, 8'h0B, 54'h800);
    prv = 2'd0; mprv = 1'b0;
    apply_cfg();
    send(56'h0FFC, 2'd1, 4'd8, 4'd1, 1'b1, 1'b1);
    send(56'h0FF8, 2'd1, 4'd8, 4'd2, 1'b0, 1'b1);
    send(56'h0FFF, 2'd2, 4'd1, 4'd3, 1'b0, 1'b1);
    send(56'h1800, 2'd2, 4'd8, 4'd4, 1'b0, 1'b1);
    send(56'h1800, 2'd0, 4'd4, 4'd5, 1'b1, 1'b1);
    send(56'h2000, 2'd1, 4'd4, 4'd6, 1'b1, 1'b1);
    idle();
    wait_drain("tor");
    check_cnt("tor");
  endtask

  task automatic test_mprv();
    clear_cfg();
    set_entry(3, 8'h91, 54'h1000);
    prv = 2'd3; mprv = 1'b1; mpp = 2'd0;
    apply_cfg();
    send(56'h9000_0000, 2'd1, 4'd8, 4'd1, 1'b1, 1'b1);
    send(56'h9000_0000, 2'd0, 4'd4, 4'd2, 1'b0, 1'b1);
    idle();
    mprv = 1'b0;
    send(56'h4000, 2'd2, 4'd4, 4'd3, 1'b1, 1'b1);
    send(56'h4000, 2'd1, 4'd4, 4'd4, 1'b0, 1'b1);
    send(56'h4000, 2'd1, 4'd8, 4'd5, 1'b1, 1'b1);
    send(56'h9000_0000, 2'd2, 4'd8, 4'd6, 1'b0, 1'b1);
    mprv = 1'b1; mpp = 2'd3;
    send(56'h9000_0000, 2'd1, 4'd8, 4'd7, 1'b0, 1'b1);
    idle();
    wait_drain("mprv");
    check_cnt("mprv");
  endtask

  task automatic test_back_to_back();
    clear_cfg();
    set_entry(0, 8'h19, 54'h2000_01FF);
    prv = 2'd0; mprv = 1'b0; mpp = 2'd0;
    apply_cfg();
    resp_ready = 1'b0;
    fork
      begin
        send(56'h8000_0010, 2'd1, 4'd8, 4'd4, 1'b0, 1'b0);
        send(56'h8000_0020, 2'd2, 4'd8, 4'd5, 1'b1, 1'b0);
        send(56'h8000_0030, 2'd1, 4'd4, 4'd6, 1'b0, 1'b0);
        send(56'h8000_0040, 2'd2, 4'd4, 4'd7, 1'b1, 1'b0);
        idle();
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid} !== 2'b01) begin
          n_err++;
          $display("FAIL b2b_stall: got req_ready=%0b resp_valid=%0b, want 0 1", req_ready, resp_valid);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
      end
    join
    wait_drain("b2b");
    check_cnt("b2b");
  endtask

  task automatic test_cfg_update();
    bit up = 1'b0;
    resp_ready = 1'b0;
    send(56'h8000_0000, 2'd1, 4'd8, 4'd8, 1'b0, 1'b0);
    send(56'h8000_0100, 2'd1, 4'd8, 4'd9, 1'b0, 1'b0);
    idle();
    set_entry(0, 8'h1A, 54'h2000_01FF);
    cfg_update = 1'b1;
    @(posedge clk);
    #1;
    cfg_update = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL cfg_hold: got req_ready=%0b, want 0 while reload pending", req_ready);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    for (int t = 0; t < 50 && !up; t++) begin
      @(negedge clk);
      if (req_ready) up = 1'b1;
    end
    n_cmp++;
    if (!up || sb.size() != 0) begin
      n_err++;
      $display("FAIL cfg_drain: got req_ready=%0b outstanding=%0d, want 1 and 0", req_ready, sb.size());
    end
    @(posedge clk);
    #1;
    send(56'h8000_0000, 2'd1, 4'd8, 4'd10, 1'b1, 1'b1);
    send(56'h8000_0000, 2'd2, 4'd8, 4'd11, 1'b0, 1'b1);
    idle();
    wait_drain("cfg");
    check_cnt("cfg");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    resp_ready = 1'b0;
    send(56'h8000_0000, 2'd2, 4'd8, 4'd1, 1'b0, 1'b0);
    send(56'h8000_0008, 2'd2, 4'd8, 4'd2, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    exp_faults = 0;
    resp_ready = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_mid: got resp_valid high in %0d cycles after reset, want 0", bad);
    end
    @(posedge clk);
    #1;
    check_cnt("reset_mid");
  endtask

  task automatic test_pa_range();
    int n;
    clear_cfg();
    prv = 2'd3; mprv = 1'b0; mpp = 2'd0;
    resp_ready = 1'b1;
    apply_cfg();
    send(56'h1_0000_0000, 2'd1, 4'd8, 4'd1, 1'b1, 1'b1);
    send(56'hFF_FFFF_FFFF_FFFC, 2'd2, 4'd8, 4'd2, 1'b1, 1'b1);
    send(56'hFFFF_FFFC, 2'd1, 4'd4, 4'd3, 1'b0, 1'b1);
    send(56'hFFFF_FFFC, 2'd1, 4'd8, 4'd4, 1'b0, 1'b1);
    idle();
    wait_drain("pa");
    check_cnt("pa");
    n = 65535 - exp_faults + 3;
    for (int i = 0; i < n; i++) begin
      send(56'h1_0000_0000, 2'd1, 4'd8, 4'(i), 1'b1, 1'b0);
    end
    idle();
    wait_drain("sat");
    check_cnt("sat");
    send(56'h2_0000_0000, 2'd2, 4'd8, 4'd5, 1'b1, 1'b1);
    idle();
    wait_drain("sat2");
    check_cnt("sat2");
  endtask

  initial begin
    rst = 1'b1;
    cfg_update = 1'b0;
    pmpcfg = '0;
    pmpaddr = '0;
    prv = 2'd3;
    mprv = 1'b0;
    mpp = 2'd0;
    req_valid = 1'b0;
    req_paddr = '0;
    req_type = '0;
    req_bytes = 4'd1;
    req_id = '0;
    resp_ready = 1'b1;
    test_reset();
    test_napot();
    test_tor();
    test_mprv();
    test_back_to_back();
    test_cfg_update();
    test_reset_mid();
    test_pa_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
